cpu_control_sequencer: RTL and testbench
========================================

Name: cpu_control_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit processor.
- Sits between instruction memory, the instruction decoder, register file, ALU, flag register and PC.
- Fetches one 16-bit instruction per pass and captures its opcode and flag-enable bit.
- Emits one-cycle strobes that sequence ALU, load/store, branch and halt instructions.

Parameters:
- OP_W, 4, opcode width (instr[15:12]).
- STATE_W, 3, width of the debug state output.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  instruction fetch request.
- imem_ready  input  1  instruction word valid this cycle.
- instr  input  16  instruction word from instruction memory.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  data memory write (1=store, 0=load); valid with dmem_req.
- dmem_ready  input  1  data access complete this cycle.
- flag_z  input  1  registered zero flag.
- flag_n  input  1  registered negative flag.
- ir_load  output  1  load external instruction register.
- pc_inc  output  1  PC <= PC+1.
- pc_load  output  1  PC <= branch target (decoder immediate path).
- alu_en  output  1  ALU operation strobe.
- flag_we  output  1  flag register write strobe.
- reg_we  output  1  register file write strobe (DEST field).
- wb_sel  output  1  writeback source: 0=ALU, 1=data memory.
- halted  output  1  core halted.
- state  output  STATE_W  current FSM state, for debug.

Behaviour:
- Opcode map:
  - 0x0-0x8: ALU register/immediate ops.
  - 0x9: LOAD.
  - 0xA: STORE.
  - 0xB: B (always taken).
  - 0xC: BEQ (taken if Z).
  - 0xD: BNE (taken if !Z).
  - 0xE: BLT (taken if N).
  - 0xF: HALT.
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6-7 are illegal and go to FETCH on the next clock.
- Reset (async, rst_n=0):
  - state=FETCH; all strobes, imem_req, dmem_req and halted = 0.
  - op_q=0, fen_q=0.
  - imem_req rises combinationally in FETCH after reset release.
- FETCH:
  - imem_req=1, held until imem_ready.
  - On imem_ready: ir_load=1, pc_inc=1, op_q<=instr[15:12], fen_q<=instr[1]; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: no strobes; next state EXEC.
- EXEC:
  - ALU op: alu_en=1, flag_we=fen_q; next WB.
  - LOAD/STORE: alu_en=1 (address calculation); next MEM.
  - Branch: pc_load=1 if the condition is true on the current flags, else no strobe; next FETCH.
  - HALT: next HALT.
- MEM:
  - dmem_req=1 and dmem_we=(op_q==0xA), held until dmem_ready.
  - On dmem_ready: STORE goes to FETCH; LOAD goes to WB.
- WB: reg_we=1, wb_sel=(op_q==0x9); next FETCH.
- HALT: halted=1; no other strobes; exit only by reset.
- All strobes are Moore/Mealy single-cycle pulses, asserted only in the state listed. pc_inc and pc_load are never asserted together.
- Latency, with imem_ready and dmem_ready asserted in the same cycle as the request:
  - ALU: 4 cycles.
  - Branch: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Every wait cycle adds 1.
- Branch conditions sample flag_z and flag_n in EXEC. A flag_we from the previous instruction is already registered by then.
- imem_ready or dmem_ready seen outside its own request state is ignored.
- rst_n low mid-access: immediate return to FETCH. Requests drop asynchronously and no strobe is produced for the aborted instruction.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - retired_cnt[15:0]: increments on each return to FETCH from EXEC, MEM or WB, and on entry to HALT.
  - stall_cnt[15:0]: increments on each cycle in FETCH or MEM with the ready signal low.
- Both counters reset to 0, wrap 0xFFFF->0x0000, and freeze in HALT.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then ADD (instr=0x0A83, fen=1), imem_ready tied 1:
  - ir_load and pc_inc at cycle 1, alu_en and flag_we at cycle 3, reg_we with wb_sel=0 at cycle 4.
  - imem_req re-asserts at cycle 5.
- LOAD (op 0x9) with dmem_ready delayed 3 cycles:
  - dmem_req high 4 cycles with dmem_we=0, then reg_we=1 with wb_sel=1.
  - Total 8 cycles.
- BEQ (0xC) with flag_z=1 gives pc_load pulse in EXEC. The same instr with flag_z=0 gives no pc_load.
- STORE (0xA) with dmem_ready=1: dmem_we=1 for one cycle and no reg_we; back in FETCH after 4 cycles.
- HALT (0xF): halted=1 and stays high for 20 cycles, with no strobes and no imem_req. A subsequent rst_n pulse returns state=0.
- rst_n asserted during MEM with dmem_ready=0: dmem_req drops with no clock edge needed, and reg_we is never asserted. Under CTRL_PERF_CNT_EN, retired_cnt and stall_cnt read 0 after reset.

Source files
------------

// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM for the 16-bit core.
// Optional performance counters are enabled with CTRL_PERF_CNT_EN.
module cpu_control_sequencer #(
    parameter int OP_W    = 4,
    parameter int STATE_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    input  logic               imem_ready,
    input  logic [15:0]        instr,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ready,
    input  logic               flag_z,
    input  logic               flag_n,
    output logic               ir_load,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               alu_en,
    output logic               flag_we,
    output logic               reg_we,
    output logic               wb_sel,
    output logic               halted,
    output logic [STATE_W-1:0] state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [15:0]        retired_cnt,
    output logic [15:0]        stall_cnt
`endif
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    localparam logic [OP_W-1:0] OP_ALU_MAX = OP_W'(8);
    localparam logic [OP_W-1:0] OP_LOAD    = OP_W'(9);
    localparam logic [OP_W-1:0] OP_STORE   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_B       = OP_W'(11);
    localparam logic [OP_W-1:0] OP_BEQ     = OP_W'(12);
    localparam logic [OP_W-1:0] OP_BNE     = OP_W'(13);
    localparam logic [OP_W-1:0] OP_BLT     = OP_W'(14);
    localparam logic [OP_W-1:0] OP_HALT    = OP_W'(15);

    state_e          state_q, state_d;
    logic [OP_W-1:0] op_q;
    logic            fen_q;
    logic            is_alu, is_mem, is_br, taken;
    logic            unused_bits;

    assign unused_bits = ^{instr[15-OP_W:2], instr[0]};
    assign is_alu = op_q <= OP_ALU_MAX;
    assign is_mem = (op_q == OP_LOAD) || (op_q == OP_STORE);
    assign is_br  = (op_q >= OP_B) && (op_q <= OP_BLT);
    assign taken  = (op_q == OP_B) || (op_q == OP_BEQ && flag_z) ||
                    (op_q == OP_BNE && !flag_z) || (op_q == OP_BLT && flag_n);

    // Gating with rst_n drops every request the instant reset asserts, without a clock edge.
    assign imem_req = rst_n && state_q == FETCH;
    assign ir_load  = imem_req && imem_ready;
    assign pc_inc   = ir_load;
    assign alu_en   = rst_n && state_q == EXEC && (is_alu || is_mem);
    assign flag_we  = rst_n && state_q == EXEC && is_alu && fen_q;
    assign pc_load  = rst_n && state_q == EXEC && is_br && taken;
    assign dmem_req = rst_n && state_q == MEM;
    assign dmem_we  = dmem_req && op_q == OP_STORE;
    assign reg_we   = rst_n && state_q == WB;
    assign wb_sel   = reg_we && op_q == OP_LOAD;
    assign halted   = rst_n && state_q == HALT;
    assign state    = STATE_W'(state_q);

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = imem_ready ? DECODE : FETCH;
            DECODE:  state_d = EXEC;
            EXEC:    state_d = is_alu ? WB : is_mem ? MEM : op_q == OP_HALT ? HALT : FETCH;
            MEM:     state_d = !dmem_ready ? MEM : op_q == OP_STORE ? FETCH : WB;
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            op_q    <= '0;
            fen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ir_load) begin
                op_q  <= instr[15:16-OP_W];
                fen_q <= instr[1];
            end
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [15:0] retired_q, stall_q;
    logic        retire, stall;

    assign retire = (state_d == FETCH && (state_q == EXEC || state_q == MEM || state_q == WB)) ||
                    (state_d == HALT && state_q == EXEC);
    assign stall  = (state_q == FETCH && !imem_ready) || (state_q == MEM && !dmem_ready);
    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_q + 16'(retire);
            stall_q   <= stall_q + 16'(stall);
        end
    end
`endif
endmodule

// File: tb/tb_cpu_control_sequencer.sv
// tb_cpu_control_sequencer: directed per-cycle checks of the control sequencer strobes and state.
module tb_cpu_control_sequencer;
    logic        clk = 0, rst_n = 0, imem_ready = 0, dmem_ready = 0, flag_z = 0, flag_n = 0;
    logic [15:0] instr = 0;
    logic        imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, alu_en, flag_we;
    logic        reg_we, wb_sel, halted;
    logic [2:0]  state;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0] retired_cnt, stall_cnt;
`endif
    int checks = 0, fails = 0;

    localparam logic [10:0] IREQ = 11'h400, IRL = 11'h200, PCI = 11'h100, ALU = 11'h080;
    localparam logic [10:0] FWE = 11'h040, PCL = 11'h020, DREQ = 11'h010, DWE = 11'h008;
    localparam logic [10:0] RWE = 11'h004, WBS = 11'h002, HLT = 11'h001;
    localparam logic [10:0] FET = IREQ | IRL | PCI;

    wire [13:0] obs = {state, imem_req, ir_load, pc_inc, alu_en, flag_we, pc_load,
                       dmem_req, dmem_we, reg_we, wb_sel, halted};

    always #5 clk = ~clk;

    cpu_control_sequencer dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ready(imem_ready), .instr(instr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready), .flag_z(flag_z),
        .flag_n(flag_n), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .alu_en(alu_en),
        .flag_we(flag_we), .reg_we(reg_we), .wb_sel(wb_sel), .halted(halted), .state(state)
`ifdef CTRL_PERF_CNT_EN
        , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
    );

    task automatic test_reset();
        #1;
        checks++;
        if (obs !== 14'h0) begin fails++; $display("FAIL reset_state: got %h want %h", obs, 14'h0); end
        rst_n = 1;
        #1;
        checks++;
        if (obs !== {3'd0, IREQ}) begin fails++; $display("FAIL reset_release: got %h want %h", obs, {3'd0, IREQ}); end
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [15:0] ins [9];
        logic [1:0]  r [9];
        logic [13:0] e [9];
        ins = '{16'h0A83, 16'h0A83, 16'h0A83, 16'h0A83, 16'h0A83, 16'h1000, 16'h1000, 16'h1000, 16'h1000};
        r   = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        e   = '{{3'd0, FET}, {3'd1, 11'h0}, {3'd2, ALU | FWE}, {3'd4, RWE}, {3'd0, IREQ},
                {3'd0, FET}, {3'd1, 11'h0}, {3'd2, ALU}, {3'd4, RWE}};
        for (int i = 0; i < 9; i++) begin
            instr = ins[i];
            {imem_ready, dmem_ready} = r[i];
            #1;
            checks++;
            if (obs !== e[i]) begin fails++; $display("FAIL add cycle %0d: got %h want %h", i + 1, obs, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_load();
        logic [1:0]  r [8];
        logic [13:0] e [8];
        r = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        e = '{{3'd0, FET}, {3'd1, 11'h0}, {3'd2, ALU}, {3'd3, DREQ}, {3'd3, DREQ},
              {3'd3, DREQ}, {3'd3, DREQ}, {3'd4, RWE | WBS}};
        instr = 16'h9123;
        for (int i = 0; i < 8; i++) begin
            {imem_ready, dmem_ready} = r[i];
            #1;
            checks++;
            if (obs !== e[i]) begin fails++; $display("FAIL load cycle %0d: got %h want %h", i + 1, obs, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [15:0] ins [8];
        logic [2:0]  v [8];
        ins = '{16'hB000, 16'hC000, 16'hC000, 16'hD000, 16'hD000, 16'hE000, 16'hE000, 16'hE000};
        v   = '{3'b001, 3'b101, 3'b000, 3'b001, 3'b100, 3'b011, 3'b000, 3'b100};
        for (int k = 0; k < 8; k++) begin
            instr = ins[k];
            {flag_z, flag_n} = v[k][2:1];
            imem_ready = 1;
            #1;
            checks++;
            if (obs !== {3'd0, FET}) begin fails++; $display("FAIL branch%0d fetch: got %h want %h", k, obs, {3'd0, FET}); end
            @(negedge clk);
            imem_ready = 0;
            #1;
            checks++;
            if (obs !== {3'd1, 11'h0}) begin fails++; $display("FAIL branch%0d decode: got %h want %h", k, obs, {3'd1, 11'h0}); end
            @(negedge clk);
            #1;
            checks++;
            if (obs !== {3'd2, v[k][0] ? PCL : 11'h0})
                begin fails++; $display("FAIL branch%0d exec: got %h want %h", k, obs, {3'd2, v[k][0] ? PCL : 11'h0}); end
            @(negedge clk);
        end
        flag_z = 0;
        flag_n = 0;
    endtask

    task automatic test_store();
        logic [1:0]  r [5];
        logic [13:0] e [5];
        r = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
        e = '{{3'd0, FET}, {3'd1, 11'h0}, {3'd2, ALU}, {3'd3, DREQ | DWE}, {3'd0, IREQ}};
        instr = 16'hA456;
        for (int i = 0; i < 5; i++) begin
            {imem_ready, dmem_ready} = r[i];
            #1;
            checks++;
            if (obs !== e[i]) begin fails++; $display("FAIL store cycle %0d: got %h want %h", i + 1, obs, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        logic [1:0]  r [4];
        logic [13:0] e [4];
        r = '{2'b10, 2'b00, 2'b00, 2'b00};
        e = '{{3'd0, FET}, {3'd1, 11'h0}, {3'd2, ALU}, {3'd3, DREQ}};
        instr = 16'h9000;
        for (int i = 0; i < 4; i++) begin
            {imem_ready, dmem_ready} = r[i];
            #1;
            checks++;
            if (obs !== e[i]) begin fails++; $display("FAIL abort cycle %0d: got %h want %h", i + 1, obs, e[i]); end
            @(negedge clk);
        end
        #1;
        rst_n = 0;
        #1;
        checks++;
        if (obs !== 14'h0) begin fails++; $display("FAIL abort_async_drop: got %h want %h", obs, 14'h0); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            dmem_ready = 1;
            #1;
            checks++;
            if (reg_we !== 1'b0) begin fails++; $display("FAIL abort_no_reg_we: got %b want 0", reg_we); end
        end
`ifdef CTRL_PERF_CNT_EN
        checks++;
        if (retired_cnt !== 16'h0 || stall_cnt !== 16'h0)
            begin fails++; $display("FAIL perf_reset: got %h/%h want 0/0", retired_cnt, stall_cnt); end
`endif
        dmem_ready = 0;
        imem_ready = 0;
        rst_n = 1;
        #1;
        checks++;
        if (obs !== {3'd0, IREQ}) begin fails++; $display("FAIL abort_release: got %h want %h", obs, {3'd0, IREQ}); end
        @(negedge clk);
    endtask

    task automatic test_halt();
        logic [13:0] e [3];
        e = '{{3'd0, FET}, {3'd1, 11'h0}, {3'd2, 11'h0}};
        instr = 16'hF000;
        for (int i = 0; i < 3; i++) begin
            imem_ready = (i == 0);
            #1;
            checks++;
            if (obs !== e[i]) begin fails++; $display("FAIL halt_entry cycle %0d: got %h want %h", i + 1, obs, e[i]); end
            @(negedge clk);
        end
        for (int i = 0; i < 20; i++) begin
            imem_ready = i[0];
            dmem_ready = !i[0];
            #1;
            checks++;
            if (obs !== {3'd5, HLT}) begin fails++; $display("FAIL halt_hold cycle %0d: got %h want %h", i, obs, {3'd5, HLT}); end
            @(negedge clk);
        end
        imem_ready = 0;
        dmem_ready = 0;
        rst_n = 0;
        #1;
        checks++;
        if (obs !== 14'h0) begin fails++; $display("FAIL halt_reset: got %h want %h", obs, 14'h0); end
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++;
        if (obs !== {3'd0, IREQ}) begin fails++; $display("FAIL halt_release: got %h want %h", obs, {3'd0, IREQ}); end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_add();
        test_load();
        test_branch();
        test_store();
        test_abort();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
